// File: rtl/fifo_ctrl.sv
// FIFO control engine: accepts push/pop requests, generates memory pointers and strobes,
// tracks occupancy and produces full/empty, threshold, read-valid and sticky error flags.
module fifo_ctrl #(
    parameter int MEM_SIZE  = 8,   // must equal 2**PTR so pointers wrap naturally
    parameter int WORD_SIZE = 10,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_req,
    input  logic                 pop_req,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [PTR-1:0]       umbral_af,
    input  logic [PTR-1:0]       umbral_ae,
    output logic [PTR-1:0]       wr_ptr,
    output logic [PTR-1:0]       rd_ptr,
    output logic                 push,
    output logic                 pop,
    output logic [WORD_SIZE-1:0] data_in_MM,
    output logic [PTR:0]         count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 data_valid,
    output logic                 error
);

    localparam logic [PTR:0]   DEPTH   = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR-1:0] PTR_ONE = PTR'(1);
    localparam logic [PTR:0]   CNT_ONE = (PTR+1)'(1);

    logic [PTR-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR:0]   count_reg, count_next;
    logic           data_valid_reg;
    logic           error_reg, error_next;

    logic           push_acc;
    logic           pop_acc;
    logic           overflow;
    logic           underflow;
    logic [PTR:0]   af_level;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH);

    // Strobes are masked while reset is held so a request coincident with reset is dropped.
    assign pop_acc  = pop_req & ~empty & ~reset;
    assign push_acc = push_req & (~full | pop_acc) & ~reset;

    assign overflow  = push_req & full & ~pop_acc;
    assign underflow = pop_req & empty;

    assign af_level     = DEPTH - {1'b0, umbral_af};
    assign almost_full  = (count_reg >= af_level);
    assign almost_empty = (count_reg <= {1'b0, umbral_ae});

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        error_next  = error_reg | overflow | underflow;
        if (push_acc) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            // Memory read data is registered, so valid trails the accepted pop by one cycle.
            data_valid_reg <= pop_acc;
            error_reg      <= error_next;
        end
    end

    assign wr_ptr     = wr_ptr_reg;
    assign rd_ptr     = rd_ptr_reg;
    assign push       = push_acc;
    assign pop        = pop_acc;
    assign data_in_MM = data_in;
    assign count      = count_reg;
    assign data_valid = data_valid_reg;
    assign error      = error_reg;

endmodule
